div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Shares one pipelined restoring fraction divider between two requesters, e.g. the FP divide unit and the normaliser.
- Arbitrates requests round-robin and drives the divider operands.
- Tracks in-flight operations with a tag pipeline matched to the divider latency.
- Steers each result into a per-requester response FIFO.
- The divider pipeline has no stall input, so issue is credit-gated: every accepted request is guaranteed a FIFO slot.

Parameters:
- WIDTH, 26, operand/quotient width; must match the divider.
- STAGES, 2, divider stage count; the divider has STAGES-1 register stages (LAT = STAGES-1, 0 allowed).
- FIFO_DEPTH, 4, entries per response FIFO; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  2  request valid per requester (bit r = requester r)
- req_ready  out  2  request accepted when valid&ready
- req_num0, req_num1  in  WIDTH  numerator per requester
- req_den0, req_den1  in  WIDTH  denominator per requester
- div_num  out  WIDTH  operand to divider num
- div_den  out  WIDTH  operand to divider den
- div_quot  in  WIDTH  divider quot
- div_sticky  in  1  divider sticky
- rsp_valid  out  2  response available per requester
- rsp_ready  in  2  response consumed when valid&ready
- rsp_quot0, rsp_quot1  out  WIDTH  quotient per requester
- rsp_sticky  out  2  sticky per requester
- rsp_err  out  2  operand-error flag per requester (0 when DIV_SCHED_CHK_EN is absent)
- busy  out  1  any op in flight or any FIFO non-empty

Behaviour:
- Reset (async, rst=0):
  - credits = FIFO_DEPTH each; tag pipe cleared; FIFOs empty; rr pointer = 0.
  - All outputs 0, except div_den = 1.
  - Ops in flight at reset are discarded; no response is ever produced for them.
- Credits, per requester:
  - Decrement on issue; increment on response pop; unchanged when both occur in the same cycle.
  - Invariant: credit + in-flight + FIFO occupancy = FIFO_DEPTH.
- Eligibility: requester r is eligible when req_valid[r] and credit[r] > 0.
- Grant:
  - One eligible requester: it is granted.
  - Both eligible: grant the rr pointer's requester; the pointer then moves to the other requester.
  - Pointer changes only on a grant.
- req_ready[r] = credit[r]>0 & (pointer==r | !eligible[other]).
  - Depends on the other requester's valid, never on its own req_valid[r].
- Issue cycle:
  - div_num/div_den = granted operands, combinationally.
  - Tag {valid, id, err} enters pipe stage 0.
- Idle cycle: div_num = 0, div_den = 1.
- Tag pipe:
  - LAT registers. Tag at the output aligns with div_quot/div_sticky of the same op.
  - LAT=0: result is captured in the issue cycle.
- Retire: when the aligned tag is valid, push {div_quot, div_sticky, err} into FIFO[id].
  - Overflow is impossible by credit; the bench asserts this.
- Response latency: rsp_valid rises STAGES cycles after the accept edge (registered FIFO).
- Ordering: responses per requester in accept order; no ordering between requesters.
- FIFO: rsp_* shows the head entry; pop on rsp_valid&rsp_ready.
  - Push and pop in the same cycle on a non-empty FIFO: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Back-to-back: one issue per cycle sustained while credits allow.
- busy = |inflight | |rsp_valid.

Optional Feature:
- Macro: DIV_SCHED_CHK_EN.
- Defined: at accept, flag err when den==0 or num>den.
  - Erroneous ops still issue (keeps tag alignment) but with div_num=0, div_den=1.
  - Response has quot=0, sticky=0, rsp_err=1.
- Undefined: operands pass unchecked; rsp_err tied 0; out-of-range results are undefined.

Test Plan:
- Single op, STAGES=2: r0 num=1, den=2 accepted at edge T -> rsp_valid[0] at T+2, rsp_quot0=0x1000000, sticky=0.
- num=den=5 on r1 -> rsp_quot1=0x1FFFFFF, rsp_sticky[1]=1; rsp_valid[0] stays 0.
- Both valid every cycle, all rsp_ready=1 -> grants alternate 0,1,0,1; 8 accepts yield 4 responses each, in order; one issue per cycle.
- r0 rsp_ready=0, FIFO_DEPTH=4 -> exactly 4 r0 accepts, then req_ready[0]=0 while r1 keeps issuing every cycle. Releasing one pop -> exactly one further r0 accept.
- Assert rst low with 2 ops in flight -> all outputs at reset values immediately; no responses after release; credits back to 4.
- With DIV_SCHED_CHK_EN, r0 den=0 -> response err=1, quot=0. Following valid op num=3, den=3 -> quot=0x1FFFFFF, err=0, ordered after the error response.

Source files
------------

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one pipelined fraction divider between two requesters.
// Define DIV_SCHED_CHK_EN to flag and neutralise out-of-range operands (rsp_err).
module div_sched #(
    parameter int WIDTH      = 26,
    parameter int STAGES     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_num0,
    input  logic [WIDTH-1:0] req_num1,
    input  logic [WIDTH-1:0] req_den0,
    input  logic [WIDTH-1:0] req_den1,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    input  logic [WIDTH-1:0] div_quot,
    input  logic             div_sticky,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_quot0,
    output logic [WIDTH-1:0] rsp_quot1,
    output logic [1:0]       rsp_sticky,
    output logic [1:0]       rsp_err,
    output logic             busy
);
    localparam int LAT = STAGES - 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } tag_t;

    typedef struct packed {
        logic [WIDTH-1:0] quot;
        logic             sticky;
        logic             err;
    } entry_t;

    logic [CW-1:0]    credit [2];
    logic             ptr;
    logic [1:0]       has_credit, eligible, grant, push, pop;
    logic             gnt_id, op_err, pipe_busy;
    logic [WIDTH-1:0] num_sel, den_sel;
    tag_t             tag_in, tag_out;
    logic             ret_valid, ret_id;
    entry_t           ret_entry;
    logic [PW-1:0]    wr_ptr [2];
    logic [PW-1:0]    rd_ptr [2];
    logic [CW-1:0]    fcnt [2];
    entry_t           mem [2][FIFO_DEPTH];
    entry_t           head [2];

    // Arbitration and operand steering; reset masks the handshake so outputs sit at idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        has_credit = '0;
        for (int r = 0; r < 2; r++) has_credit[r] = rst && (credit[r] != '0);
        eligible     = req_valid & has_credit;
        req_ready[0] = has_credit[0] && (!ptr || !eligible[1]);
        req_ready[1] = has_credit[1] && (ptr || !eligible[0]);
        grant        = req_valid & req_ready;
        gnt_id       = grant[1];
        num_sel      = gnt_id ? req_num1 : req_num0;
        den_sel      = gnt_id ? req_den1 : req_den0;
`ifdef DIV_SCHED_CHK_EN
        op_err       = (den_sel == '0) || (num_sel > den_sel);
`else
        op_err       = 1'b0;
`endif
        div_num      = '0;
        div_den      = WIDTH'(1);
        if (|grant && !op_err) begin
            div_num = num_sel;
            div_den = den_sel;
        end
        tag_in = '{valid: |grant, id: gnt_id, err: op_err};
    end

    // Tag pipe mirrors the divider's register stages so tag_out lines up with div_quot.
    generate
        if (LAT == 0) begin : g_no_pipe
            assign tag_out   = tag_in;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            tag_t pipe [LAT];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= tag_in;
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            always_comb begin
                pipe_busy = 1'b0;
                for (int i = 0; i < LAT; i++) pipe_busy = pipe_busy | pipe[i].valid;
            end
            assign tag_out = pipe[LAT-1];
        end
    endgenerate

    always_comb begin
        push = '0;
        pop  = '0;
        for (int r = 0; r < 2; r++) begin
            push[r]      = ret_valid && (ret_id == r[0]);
            rsp_valid[r] = fcnt[r] != '0;
            pop[r]       = rsp_valid[r] && rsp_ready[r];
            head[r]      = rsp_valid[r] ? mem[r][rd_ptr[r]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= 1'b0;
            ret_valid <= 1'b0;
            ret_id    <= 1'b0;
            ret_entry <= '0;
            for (int r = 0; r < 2; r++) begin
                credit[r] <= CW'(FIFO_DEPTH);
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                fcnt[r]   <= '0;
            end
        end else begin
            if (|grant) ptr <= ~gnt_id;
            ret_valid <= tag_out.valid;
            ret_id    <= tag_out.id;
            if (tag_out.err) ret_entry <= '{quot: '0, sticky: 1'b0, err: 1'b1};
            else             ret_entry <= '{quot: div_quot, sticky: div_sticky, err: 1'b0};
            for (int r = 0; r < 2; r++) begin
                credit[r] <= credit[r] - CW'(grant[r]) + CW'(pop[r]);
                fcnt[r]   <= fcnt[r] + CW'(push[r]) - CW'(pop[r]);
                if (push[r]) wr_ptr[r] <= wr_ptr[r] + 1'b1;
                if (pop[r])  rd_ptr[r] <= rd_ptr[r] + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; only the pointers and counts decide what is visible.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++)
            if (push[r]) mem[r][wr_ptr[r]] <= ret_entry;
    end

    assign rsp_quot0  = head[0].quot;
    assign rsp_quot1  = head[1].quot;
    assign rsp_sticky = {head[1].sticky, head[0].sticky};
    assign rsp_err    = {head[1].err, head[0].err};
    assign busy       = pipe_busy | ret_valid | (|rsp_valid);
endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: includes a behavioural divider and a queue-based reference model.
module tb_div_sched;
    localparam int WIDTH      = 26;
    localparam int STAGES     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int LAT        = STAGES - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [WIDTH-1:0] req_num0 = '0, req_num1 = '0, req_den0 = '0, req_den1 = '0;
    logic [WIDTH-1:0] div_num, div_den, div_quot, rsp_quot0, rsp_quot1;
    logic             div_sticky, busy;
    logic [1:0]       rsp_sticky, rsp_err;

    div_sched #(.WIDTH(WIDTH), .STAGES(STAGES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num0(req_num0), .req_num1(req_num1), .req_den0(req_den0), .req_den1(req_den1),
        .div_num(div_num), .div_den(div_den), .div_quot(div_quot), .div_sticky(div_sticky),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quot0(rsp_quot0), .rsp_quot1(rsp_quot1),
        .rsp_sticky(rsp_sticky), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] quot;
        logic             sticky;
        logic             err;
        int               due;
    } exp_t;

    exp_t       q0[$], q1[$];
    int         n_checks = 0, n_fail = 0, cyc = 0;
    logic       mptr = 1'b0;
    logic [1:0] last_acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Fraction num/den scaled by 2^(WIDTH-1); num==den saturates to all ones with sticky set.
    function automatic logic [WIDTH:0] frac_div(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        logic [63:0] scaled, q, rm;
        if (d == '0) return '0;
        if (n >= d) return {1'b1, WIDTH'((64'd1 << (WIDTH-1)) - 64'd1)};
        scaled = 64'(n) << (WIDTH-1);
        q      = scaled / 64'(d);
        rm     = scaled % 64'(d);
        return {rm != 64'd0, WIDTH'(q)};
    endfunction

    function automatic logic op_err(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
`ifdef DIV_SCHED_CHK_EN
        return (d == '0) || (n > d);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t expect_rsp(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d, input int now);
        exp_t e;
        e.due = now + 1 + STAGES;
        e.err = op_err(n, d);
        if (e.err) begin
            e.quot   = '0;
            e.sticky = 1'b0;
        end else begin
            {e.sticky, e.quot} = frac_div(n, d);
        end
        return e;
    endfunction

    // Stand-in for the external divider: LAT register stages, no stall.
    generate
        if (LAT == 0) begin : g_div_comb
            assign {div_sticky, div_quot} = frac_div(div_num, div_den);
        end else begin : g_div_pipe
            logic [WIDTH:0] dp [LAT];
            always @(posedge clk) begin
                dp[0] <= frac_div(div_num, div_den);
                for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
            end
            assign {div_sticky, div_quot} = dp[LAT-1];
        end
    endgenerate

    task automatic rand_op(output logic [WIDTH-1:0] n, output logic [WIDTH-1:0] d);
        if ($urandom_range(0, 3) == 0) d = WIDTH'($urandom_range(1, 15));
        else                           d = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
        n = WIDTH'($urandom_range(0, 32'(d)));
`ifdef DIV_SCHED_CHK_EN
        if ($urandom_range(0, 9) == 0) d = '0;
        else if ($urandom_range(0, 9) == 0 && d < WIDTH'(1000)) n = d + WIDTH'(1);
`endif
    endtask

    task automatic set_in(input logic [1:0] v, input logic [1:0] rr);
        req_valid = v;
        rsp_ready = rr;
        rand_op(req_num0, req_den0);
        rand_op(req_num1, req_den1);
    endtask

    // Compares handshake, operands and busy against the model, then records accepts.
    task automatic step();
        logic [1:0]       ok, elig, exp_ready, acc;
        logic [WIDTH-1:0] en, ed;
        #1;
        ok[0] = rst && (q0.size() < FIFO_DEPTH);
        ok[1] = rst && (q1.size() < FIFO_DEPTH);
        check("busy", 64'(busy), 64'(rst && (q0.size() + q1.size() != 0)));
        elig         = req_valid & ok;
        exp_ready[0] = ok[0] && (!mptr || !elig[1]);
        exp_ready[1] = ok[1] && (mptr || !elig[0]);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        acc      = req_valid & exp_ready;
        last_acc = req_valid & req_ready;
        en = '0;
        ed = WIDTH'(1);
        if (acc[0]) begin
            q0.push_back(expect_rsp(req_num0, req_den0, cyc));
            mptr = 1'b1;
            if (!op_err(req_num0, req_den0)) begin en = req_num0; ed = req_den0; end
        end else if (acc[1]) begin
            q1.push_back(expect_rsp(req_num1, req_den1, cyc));
            mptr = 1'b0;
            if (!op_err(req_num1, req_den1)) begin en = req_num1; ed = req_den1; end
        end
        check("div_num", 64'(div_num), 64'(en));
        check("div_den", 64'(div_den), 64'(ed));
    endtask

    task automatic reset_checks();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_div_num", 64'(div_num), 64'd0);
        check("rst_div_den", 64'(div_den), 64'd1);
        check("rst_rsp_quot", 64'({rsp_quot1, rsp_quot0}), 64'd0);
        check("rst_rsp_flags", 64'({rsp_err, rsp_sticky}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    task automatic mon(input int r);
        exp_t h;
        int   sz;
        sz = (r == 1) ? q1.size() : q0.size();
        if (rsp_valid[r]) begin
            check($sformatf("rsp_spurious%0d", r), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                h = (r == 1) ? q1[0] : q0[0];
                check($sformatf("rsp_early%0d", r), 64'(cyc >= h.due), 64'd1);
                check($sformatf("rsp_quot%0d", r), 64'((r == 1) ? rsp_quot1 : rsp_quot0), 64'(h.quot));
                check($sformatf("rsp_sticky%0d", r), 64'(rsp_sticky[r]), 64'(h.sticky));
                check($sformatf("rsp_err%0d", r), 64'(rsp_err[r]), 64'(h.err));
                if (rsp_ready[r]) begin
                    if (r == 1) void'(q1.pop_front());
                    else        void'(q0.pop_front());
                end
            end
        end else if (sz != 0) begin
            h = (r == 1) ? q1[0] : q0[0];
            check($sformatf("rsp_late%0d", r), 64'(cyc < h.due), 64'd1);
        end
    endtask

    // Monitor: independent of stimulus, runs after inputs have settled each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int r = 0; r < 2; r++) begin
                if (rst && dut.push[r])
                    check("fifo_overflow", 64'(dut.fcnt[r] == FIFO_DEPTH[$clog2(FIFO_DEPTH+1)-1:0] && !dut.pop[r]), 64'd0);
                mon(r);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        repeat (2) @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst = 1'b1;
        set_in(2'b00, 2'b11);
        step();

        // Single op r0: 1/2, then num==den on r1.
        @(negedge clk);
        set_in(2'b01, 2'b11);
        req_num0 = WIDTH'(1); req_den0 = WIDTH'(2);
        step();
        repeat (4) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end
        @(negedge clk);
        set_in(2'b10, 2'b11);
        req_num1 = WIDTH'(5); req_den1 = WIDTH'(5);
        step();
        repeat (4) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end

        // Both valid every cycle: one issue per cycle, alternating grants.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(2'b11, 2'b11);
            step();
            check("one_issue_per_cycle", 64'($countones(last_acc)), 64'd1);
        end
        repeat (6) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end

        // r0 backpressured: credit runs out after FIFO_DEPTH accepts, r1 keeps going.
        n0 = 0; n1 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(2'b11, 2'b10);
            step();
            n0 += int'(last_acc[0]);
            n1 += int'(last_acc[1]);
        end
        check("bp_r0_accepts", 64'(n0), 64'(FIFO_DEPTH));
        check("bp_r1_accepts", 64'(n1), 64'(12 - FIFO_DEPTH));
        @(negedge clk);
        set_in(2'b11, 2'b11);
        step();
        n0 = int'(last_acc[0]);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(2'b11, 2'b10);
            step();
            n0 += int'(last_acc[0]);
        end
        check("bp_release_accepts", 64'(n0), 64'd1);
        repeat (10) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end

        // Reset with two ops in flight: they must vanish.
        @(negedge clk); set_in(2'b01, 2'b11); step();
        @(negedge clk); set_in(2'b10, 2'b11); step();
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        mptr = 1'b0;
        set_in(2'b11, 2'b11);
        reset_checks();
        repeat (2) begin @(negedge clk); set_in(2'b11, 2'b11); step(); end
        @(negedge clk);
        rst = 1'b1;
        set_in(2'b00, 2'b11);
        step();
        repeat (6) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end

`ifdef DIV_SCHED_CHK_EN
        // Error op followed by a valid op on the same requester.
        @(negedge clk);
        set_in(2'b01, 2'b11);
        req_num0 = WIDTH'(7); req_den0 = '0;
        step();
        @(negedge clk);
        set_in(2'b01, 2'b11);
        req_num0 = WIDTH'(3); req_den0 = WIDTH'(3);
        step();
        repeat (6) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end
`endif

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            set_in(2'($urandom), {2'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
            step();
        end

        for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) begin
            @(negedge clk);
            set_in(2'b00, 2'b11);
            step();
        end
        check("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
        repeat (3) begin @(negedge clk); set_in(2'b00, 2'b11); step(); end
        @(negedge clk);
        #1;
        check("busy_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
